ps2_kbd_decoder: RTL and testbench
==================================

# ps2_kbd_decoder

Consumes the byte stream from the PS/2 serial receiver (`rx_data` qualified by `rx_done_tick`) and turns scan-code set 2 sequences into discrete key events. It handles the E0 (extended) and F0 (break) prefixes and tracks the shift, ctrl and caps-lock state. Each event carries a set-2 code, flags and an ASCII translation, and is buffered in a small show-ahead FIFO with a valid/ready handshake towards the application logic (text console, game controller).

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `rx_done_tick` in 1: one-cycle strobe from the receiver; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `key_ready` in 1: consumer accepts the head event.
- `key_valid` out 1: FIFO non-empty; head event is presented.
- `key_code` out 8: head event set-2 code, with prefixes stripped.
- `key_ext` out 1: head event was E0-prefixed.
- `key_break` out 1: head event is a release.
- `key_ascii` out 8: head event ASCII, 0x00 if the key is untranslatable.
- `mods` out 3: {caps_lock, ctrl, shift}, live state.
- `ovf` out 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Bytes are processed only in cycles where `rx_done_tick`=1. Bytes are ignored in all other cycles.
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE:
    - E0 goes to EXT.
    - F0 goes to BRK.
    - 00, AA, EE, FA, FE, FF and E1 are discarded and the FSM stays in IDLE.
    - Any other byte emits a make event with ext=0.
  - EXT:
    - F0 goes to EXT_BRK.
    - 12 and 59 (fake shifts) are discarded and the FSM returns to IDLE.
    - Any other byte emits a make event with ext=1 and returns to IDLE.
  - BRK: any byte emits a break event with ext=0 and returns to IDLE.
  - EXT_BRK:
    - 12 and 59 are discarded.
    - Any other byte emits a break event with ext=1.
    - Both cases return to IDLE.
- Modifiers update on every emitted event:
  - lshift (12, ext=0) and rshift (59, ext=0): make sets, break clears. `shift` = lshift | rshift.
  - lctrl (14, ext=0) and rctrl (14, ext=1): make sets, break clears. `ctrl` = lctrl | rctrl.
  - caps (58): make toggles `caps_lock` only if caps_held=0, then sets caps_held. Break clears caps_held. Typematic repeats therefore do not re-toggle.
- ASCII is computed combinationally when the event is emitted, using the modifier values registered before that event.
  - Letters: lowercase 0x61–0x7A, or uppercase 0x41–0x5A when shift XOR caps_lock.
  - Digit row: 0x30–0x39 unshifted; with shift: ! @ # $ % ^ & * ( ).
  - Space 29 → 0x20; enter 5A → 0x0D (ext=0 or ext=1); backspace 66 → 0x08; esc 76 → 0x1B; tab 0D → 0x09.
  - ctrl has no effect on ASCII. Break events carry the same ASCII as the corresponding make.
  - All other codes, and all other ext codes, give 0x00.
  - Modifier keys themselves give ASCII 0x00.
- FIFO entry is {ext, brk, code, ascii}, 18 bits.
  - Push on event emit; pop when `key_valid` & `key_ready`.
  - Push while full with no pop: the new event is dropped and `ovf` is set. Existing entries are unchanged.
  - Push and pop in the same cycle while full: both occur and nothing is dropped.
  - Pop while empty has no effect.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are derived from the MSB. Pointers wrap modulo 2·FIFO_DEPTH.

## Timing
- Reset values: FSM=IDLE, FIFO empty, `key_valid`=0, `key_code`/`key_ascii`=0x00, `key_ext`/`key_break`=0, `mods`=0, caps_held=0, `ovf`=0.
- Reset mid-sequence discards any pending prefix, all modifier state and all queued events.
- Latency: an event-completing byte tick in cycle N makes `key_valid`=1 in cycle N+1, provided the FIFO was empty.
- `mods` updates in cycle N+1.
- Head outputs remain stable while `key_valid`=1 and `key_ready`=0.
- Sustained throughput is one event per cycle. The PS/2 byte rate is far below this.

## Structure
- Package `ps2_kbd_pkg` holds:
  - the state enum;
  - the event struct;
  - localparams for prefixes, status bytes and modifier codes;
  - function `set2_to_ascii(code, ext, shift, caps)`.
- Sub-module `ps2_event_fifo` (parameter DEPTH, WIDTH=18): show-ahead FIFO with push, pop, full, empty and data. The top level contains the FSM, modifier registers and overflow flag.

## Test plan
- Byte 1C with `key_ready`=1: one event with code=1C, ext=0, brk=0, ascii=0x61. Then F0 1C: one event with brk=1, ascii=0x61.
- Sequence 12, 1C, F0 1C, F0 12, 1C: the first 1C make has ascii=0x41 and `mods`=001. The final 1C make has ascii=0x61 and `mods`=000. Five events in total.
- Sequence 58, 58, 58, F0 58, 15: caps_lock=1, toggled once. 15 gives ascii=0x51. A second 58 make after the break clears caps.
- Sequence E0 75, E0 F0 75, E0 12: two events with code=75, ext=1, brk 0 then 1, ascii=0x00. E0 12 emits nothing. FSM ends in IDLE.
- `key_ready`=0, then 5 make events with FIFO_DEPTH=4: `key_valid`=1, `ovf`=1. Draining yields exactly the first 4 events, in order. Then `key_valid`=0 and `ovf` stays 1.
- Assert `reset` after byte F0, then send 1C: the event is a make with brk=0, and `ovf`, `mods` and the FIFO are all cleared.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared types, scan-code constants and set-2 to ASCII translation
package ps2_kbd_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} prefix_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } key_event_t;

  localparam int EVENT_W = 18;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] STS_ERR0   = 8'h00;
  localparam logic [7:0] STS_BAT    = 8'hAA;
  localparam logic [7:0] STS_ECHO   = 8'hEE;
  localparam logic [7:0] STS_ACK    = 8'hFA;
  localparam logic [7:0] STS_RESEND = 8'hFE;
  localparam logic [7:0] STS_ERR1   = 8'hFF;

  localparam logic [7:0] KC_LSHIFT = 8'h12;
  localparam logic [7:0] KC_RSHIFT = 8'h59;
  localparam logic [7:0] KC_CTRL   = 8'h14;
  localparam logic [7:0] KC_CAPS   = 8'h58;
  localparam logic [7:0] KC_ENTER  = 8'h5A;

  function automatic logic is_status(input logic [7:0] b);
    return b inside {STS_ERR0, STS_BAT, STS_ECHO, STS_ACK, STS_RESEND, STS_ERR1, PFX_PAUSE};
  endfunction

  function automatic logic [7:0] set2_to_ascii(input logic [7:0] code, input logic ext,
                                               input logic shift, input logic caps);
    logic [7:0] a;
    a = 8'h00;
    if (ext) begin
      if (code == KC_ENTER) a = 8'h0D;
    end else begin
      case (code)
        8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
        8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
        8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
        8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
        8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
        8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
        8'h35: a = "y";  8'h1A: a = "z";
        8'h16: a = shift ? "!" : "1";
        8'h1E: a = shift ? "@" : "2";
        8'h26: a = shift ? "#" : "3";
        8'h25: a = shift ? "$" : "4";
        8'h2E: a = shift ? "%" : "5";
        8'h36: a = shift ? "^" : "6";
        8'h3D: a = shift ? "&" : "7";
        8'h3E: a = shift ? "*" : "8";
        8'h46: a = shift ? "(" : "9";
        8'h45: a = shift ? ")" : "0";
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        8'h66: a = 8'h08;
        8'h76: a = 8'h1B;
        8'h0D: a = 8'h09;
        default: a = 8'h00;
      endcase
      // Only the letter range is case-folded; shifted digit symbols are never in it.
      if (a >= "a" && a <= "z" && (shift ^ caps)) a = a - 8'h20;
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - show-ahead event FIFO with extra-MSB pointers
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop, do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - set-2 prefix FSM, modifier tracking and event queue
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_ascii,
  output logic [2:0] mods,
  output logic       ovf
);

  prefix_state_e st_q, st_d;
  logic emit, ev_ext, ev_brk, fake_shift;
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic caps_q, caps_d, held_q, held_d, ovf_q, ovf_d;
  logic fifo_full, fifo_empty, pop;
  logic [EVENT_W-1:0] fifo_rdata;
  key_event_t ev, head;

  assign fake_shift = (rx_data == KC_LSHIFT) || (rx_data == KC_RSHIFT);

  always_comb begin
    st_d   = st_q;
    emit   = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    if (rx_done_tick) begin
      case (st_q)
        ST_IDLE: begin
          if (rx_data == PFX_EXT)      st_d = ST_EXT;
          else if (rx_data == PFX_BRK) st_d = ST_BRK;
          else                         emit = !is_status(rx_data);
        end
        ST_EXT: begin
          st_d = ST_IDLE;
          if (rx_data == PFX_BRK) st_d = ST_EXT_BRK;
          else begin
            emit   = !fake_shift;
            ev_ext = 1'b1;
          end
        end
        ST_BRK: begin
          st_d   = ST_IDLE;
          emit   = 1'b1;
          ev_brk = 1'b1;
        end
        ST_EXT_BRK: begin
          st_d   = ST_IDLE;
          emit   = !fake_shift;
          ev_ext = 1'b1;
          ev_brk = 1'b1;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ev.ext   = ev_ext;
    ev.brk   = ev_brk;
    ev.code  = rx_data;
    ev.ascii = set2_to_ascii(rx_data, ev_ext, lshift_q | rshift_q, caps_q);
  end

  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    caps_d   = caps_q;
    held_d   = held_q;
    if (emit) begin
      if (!ev_ext && rx_data == KC_LSHIFT) lshift_d = !ev_brk;
      if (!ev_ext && rx_data == KC_RSHIFT) rshift_d = !ev_brk;
      if (!ev_ext && rx_data == KC_CTRL)   lctrl_d  = !ev_brk;
      if (ev_ext && rx_data == KC_CTRL)    rctrl_d  = !ev_brk;
      // caps_held suppresses re-toggling while typematic repeats arrive.
      if (!ev_ext && rx_data == KC_CAPS) begin
        if (ev_brk) held_d = 1'b0;
        else begin
          if (!held_q) caps_d = !caps_q;
          held_d = 1'b1;
        end
      end
    end
  end

  assign pop   = key_valid && key_ready;
  assign ovf_d = ovf_q || (emit && fifo_full && !pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      caps_q   <= 1'b0;
      held_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      lctrl_q  <= lctrl_d;
      rctrl_q  <= rctrl_d;
      caps_q   <= caps_d;
      held_q   <= held_d;
      ovf_q    <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (emit),
    .wdata_i (ev),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (fifo_rdata)
  );

  assign head      = fifo_rdata;
  assign key_valid = !fifo_empty;
  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_ascii = key_valid ? head.ascii : 8'h00;
  assign key_ext   = key_valid && head.ext;
  assign key_break = key_valid && head.brk;
  assign mods      = {caps_q, lctrl_q | rctrl_q, lshift_q | rshift_q};
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb/tb_ps2_kbd_decoder.sv - table, directed and randomized checks against a reference model
module tb_ps2_kbd_decoder;

  localparam int DEPTH = 4;

  logic       clk, reset, rx_done_tick, key_ready;
  logic [7:0] rx_data;
  logic       key_valid, key_ext, key_break, ovf;
  logic [7:0] key_code, key_ascii;
  logic [2:0] mods;

  ps2_kbd_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .key_ready    (key_ready),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .key_ascii    (key_ascii),
    .mods         (mods),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } ev_t;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       shift;
    logic [7:0] ascii;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  ev_t mq[$];
  bit  m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_caps, m_held, m_ovf;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string      symbols = ")!@#$%^&*(";

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit ext, input bit sh, input bit cp);
    if (ext) return (c == 8'h5A) ? 8'h0D : 8'h00;
    for (int i = 0; i < 26; i++)
      if (letters[i] == c) return (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (digits[i] == c) return sh ? 8'(symbols[i]) : 8'(8'h30 + i);
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h76: return 8'h1B;
      8'h0D: return 8'h09;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    {m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_caps, m_held, m_ovf} = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit emit, output ev_t ev);
    bit ext, brk, fake;
    emit = 0; ev = '0; ext = 0; brk = 0;
    fake = (b == 8'h12) || (b == 8'h59);
    if (m_brk) begin
      ext = m_ext; brk = 1; m_ext = 0; m_brk = 0;
      emit = !(ext && fake);
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else begin
        m_ext = 0; ext = 1; emit = !fake;
      end
    end else begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else emit = !(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1});
    end
    if (emit) begin
      ev = '{ext, brk, b, ref_ascii(b, ext, m_ls | m_rs, m_caps)};
      if (!ext && b == 8'h12) m_ls = !brk;
      if (!ext && b == 8'h59) m_rs = !brk;
      if (b == 8'h14) begin
        if (ext) m_rc = !brk; else m_lc = !brk;
      end
      if (!ext && b == 8'h58) begin
        if (brk) m_held = 0;
        else begin
          if (!m_held) m_caps = !m_caps;
          m_held = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", key_valid, (mq.size() != 0) ? 8'd1 : 8'd0);
    if (mq.size() != 0) begin
      chk("code", key_code, mq[0].code);
      chk("ext", key_ext, mq[0].ext);
      chk("break", key_break, mq[0].brk);
      chk("ascii", key_ascii, mq[0].ascii);
    end
    chk("mods", mods, {5'd0, m_caps, m_lc | m_rc, m_ls | m_rs});
    chk("ovf", ovf, m_ovf);
  endtask

  // One clock cycle: drive, advance the model, then compare just after the edge.
  task automatic step(input logic tick, input logic [7:0] data, input logic rdy);
    bit emit, pop;
    ev_t ev;
    rx_done_tick = tick;
    rx_data      = data;
    key_ready    = rdy;
    pop  = rdy && (mq.size() != 0);
    emit = 0;
    ev   = '0;
    if (tick) model_byte(data, emit, ev);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(ev);
    end
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  vec_t tbl[18];
  logic [7:0] pool [24];

  initial begin
    tbl[0]  = '{8'h1C, 0, 0, 0, 8'h61};
    tbl[1]  = '{8'h1C, 0, 1, 0, 8'h61};
    tbl[2]  = '{8'h1C, 0, 0, 1, 8'h41};
    tbl[3]  = '{8'h1A, 0, 0, 0, 8'h7A};
    tbl[4]  = '{8'h4D, 0, 0, 0, 8'h70};
    tbl[5]  = '{8'h16, 0, 0, 0, 8'h31};
    tbl[6]  = '{8'h16, 0, 0, 1, 8'h21};
    tbl[7]  = '{8'h45, 0, 0, 1, 8'h29};
    tbl[8]  = '{8'h36, 0, 0, 1, 8'h5E};
    tbl[9]  = '{8'h3D, 0, 0, 1, 8'h26};
    tbl[10] = '{8'h29, 0, 0, 0, 8'h20};
    tbl[11] = '{8'h5A, 1, 0, 0, 8'h0D};
    tbl[12] = '{8'h5A, 0, 0, 0, 8'h0D};
    tbl[13] = '{8'h66, 0, 0, 0, 8'h08};
    tbl[14] = '{8'h76, 0, 0, 0, 8'h1B};
    tbl[15] = '{8'h0D, 0, 0, 0, 8'h09};
    tbl[16] = '{8'h1C, 1, 0, 0, 8'h00};
    tbl[17] = '{8'h14, 0, 0, 0, 8'h00};

    pool = '{8'h1C, 8'h32, 8'h15, 8'h12, 8'h59, 8'h14, 8'h58, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66,
             8'h76, 8'h0D, 8'h75, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h00, 8'hE1, 8'h00};

    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; key_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", key_valid, 8'd0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_ascii", key_ascii, 8'h00);
    chk("rst_ext", key_ext, 8'd0);
    chk("rst_break", key_break, 8'd0);
    chk("rst_mods", mods, 8'd0);
    chk("rst_ovf", ovf, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].shift) send(8'h12);
      if (tbl[i].ext) send(8'hE0);
      if (tbl[i].brk) send(8'hF0);
      send(tbl[i].code);
      chk("tbl_valid", key_valid, 8'd1);
      chk("tbl_code", key_code, tbl[i].code);
      chk("tbl_ext", key_ext, tbl[i].ext);
      chk("tbl_break", key_break, tbl[i].brk);
      chk("tbl_ascii", key_ascii, tbl[i].ascii);
      if (!tbl[i].brk) begin
        if (tbl[i].ext) send(8'hE0);
        send(8'hF0);
        send(tbl[i].code);
      end
      if (tbl[i].shift) begin
        send(8'hF0);
        send(8'h12);
      end
      idle(2);
    end

    send(8'h12); send(8'h1C);
    chk("sh_ascii", key_ascii, 8'h41);
    chk("sh_mods", mods, 8'd1);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    chk("unsh_ascii", key_ascii, 8'h61);
    chk("unsh_mods", mods, 8'd0);
    idle(2);

    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_mods", mods, 8'd4);
    send(8'h15);
    chk("caps_ascii", key_ascii, 8'h51);
    send(8'h58);
    idle(1);
    chk("caps_off", mods, 8'd0);
    send(8'hF0); send(8'h58);
    idle(2);

    send(8'hE0); send(8'h75);
    chk("ext_make", {key_ext, key_break}, 8'd2);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_break", {key_ext, key_break}, 8'd3);
    send(8'hE0); send(8'h12);
    idle(2);
    chk("fake_none", key_valid, 8'd0);
    send(8'h1C);
    chk("idle_after", {key_ext, key_break}, 8'd0);
    idle(2);

    step(1'b1, 8'h1C, 1'b0); step(1'b1, 8'h32, 1'b0); step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h23, 1'b0); step(1'b1, 8'h24, 1'b0);
    chk("ovf_valid", key_valid, 8'd1);
    chk("ovf_set", ovf, 8'd1);
    step(1'b0, 8'h00, 1'b1); chk("drain1", key_code, 8'h32);
    step(1'b0, 8'h00, 1'b1); chk("drain2", key_code, 8'h21);
    step(1'b0, 8'h00, 1'b1); chk("drain3", key_code, 8'h23);
    step(1'b0, 8'h00, 1'b1);
    chk("drained", key_valid, 8'd0);
    chk("ovf_sticky", ovf, 8'd1);

    send(8'h12);
    send(8'hF0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", key_valid, 8'd0);
    chk("arst_mods", mods, 8'd0);
    chk("arst_ovf", ovf, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h1C);
    chk("arst_brk", key_break, 8'd0);
    chk("arst_ascii", key_ascii, 8'h61);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      logic       rdy, tick;
      int         k;
      k    = $urandom_range(0, 23);
      b    = (k == 23) ? 8'($urandom_range(0, 255)) : pool[k];
      tick = ($urandom_range(0, 1) == 1);
      rdy  = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(tick, b, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
